// File: rtl/imm_gen_pipe.sv
// Two-stage pipelined immediate generator for RV32I/RV64I decode.
// Stage 1 captures the instruction; stage 2 resolves the format and registers the immediate.
module imm_gen_pipe #(
  parameter int unsigned XLEN     = 64,
  parameter bit          AUTO_FMT = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_in_valid,
  output logic            o_in_ready_c,
  input  logic [31:0]     i_instruction,
  input  logic [2:0]      i_selection,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_value,
  output logic [2:0]      o_fmt,
  output logic            o_illegal
);

  localparam int unsigned INST_W = 32;
  localparam int unsigned FMT_W  = 3;
  localparam int unsigned OPC_W  = 7;

  localparam logic [FMT_W-1:0] FMT_NONE = 3'd0;
  localparam logic [FMT_W-1:0] FMT_I    = 3'd1;
  localparam logic [FMT_W-1:0] FMT_U    = 3'd2;
  localparam logic [FMT_W-1:0] FMT_S    = 3'd3;
  localparam logic [FMT_W-1:0] FMT_B    = 3'd4;
  localparam logic [FMT_W-1:0] FMT_J    = 3'd5;

  localparam logic [OPC_W-1:0] OPC_LOAD     = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [OPC_W-1:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_JALR     = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [OPC_W-1:0] OPC_LUI      = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_STORE    = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL      = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_OP       = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP32     = 7'b0111011;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [FMT_W-1:0]  sel;
  } s1_payload_t;

  logic              r_s1_valid;
  s1_payload_t       r_s1;
  logic              r_out_valid;
  logic [XLEN-1:0]   r_value;
  logic [FMT_W-1:0]  r_fmt;
  logic              r_illegal;

  logic              w_s2_en;
  logic              w_s1_en;
  logic [OPC_W-1:0]  w_opcode;
  logic [2:0]        w_funct3;
  logic [FMT_W-1:0]  w_fmt;
  logic              w_illegal;
  logic              w_is_shift;
  logic [XLEN-1:0]   w_shamt;
  logic [XLEN-1:0]   w_value;

  logic signed [11:0] w_imm_i;
  logic signed [31:0] w_imm_u;
  logic signed [11:0] w_imm_s;
  logic signed [12:0] w_imm_b;
  logic signed [20:0] w_imm_j;

  assign w_s2_en      = !r_out_valid || i_out_ready;
  assign w_s1_en      = !r_s1_valid || w_s2_en;
  assign o_in_ready_c = w_s1_en;

  assign w_opcode = r_s1.inst[6:0];
  assign w_funct3 = r_s1.inst[14:12];

  // Raw immediate fields; the signed types let a sized cast do the sign extension.
  assign w_imm_i = r_s1.inst[31:20];
  assign w_imm_u = {r_s1.inst[31:12], 12'h000};
  assign w_imm_s = {r_s1.inst[31:25], r_s1.inst[11:7]};
  assign w_imm_b = {r_s1.inst[31], r_s1.inst[7], r_s1.inst[30:25], r_s1.inst[11:8], 1'b0};
  assign w_imm_j = {r_s1.inst[31], r_s1.inst[19:12], r_s1.inst[20], r_s1.inst[30:21], 1'b0};

  // Format resolution, illegal-opcode detection and shift-amount override.
  always_comb begin
    w_fmt      = FMT_NONE;
    w_illegal  = 1'b0;
    w_is_shift = 1'b0;
    w_shamt    = '0;
    if (AUTO_FMT) begin
      case (w_opcode)
        OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: w_fmt = FMT_I;
        OPC_OP_IMM32: begin
          if (XLEN == 64) w_fmt = FMT_I;
          else            w_illegal = 1'b1;
        end
        OPC_LUI, OPC_AUIPC: w_fmt = FMT_U;
        OPC_STORE:          w_fmt = FMT_S;
        OPC_BRANCH:         w_fmt = FMT_B;
        OPC_JAL:            w_fmt = FMT_J;
        OPC_OP:             w_fmt = FMT_NONE;
        OPC_OP32: begin
          if (XLEN != 64) w_illegal = 1'b1;
        end
        default:            w_illegal = 1'b1;
      endcase
      if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
        if (w_opcode == OPC_OP_IMM) begin
          w_is_shift = 1'b1;
          w_shamt    = (XLEN == 64) ? XLEN'(r_s1.inst[25:20]) : XLEN'(r_s1.inst[24:20]);
        end else if (w_opcode == OPC_OP_IMM32 && XLEN == 64) begin
          w_is_shift = 1'b1;
          w_shamt    = XLEN'(r_s1.inst[24:20]);
        end
      end
    end else begin
      case (r_s1.sel)
        FMT_I, FMT_U, FMT_S, FMT_B, FMT_J: w_fmt = r_s1.sel;
        default:                           w_fmt = FMT_NONE;
      endcase
    end
  end

  // Immediate select and sign extension.
  always_comb begin
    w_value = '0;
    case (w_fmt)
      FMT_I:   w_value = XLEN'(w_imm_i);
      FMT_U:   w_value = XLEN'(w_imm_u);
      FMT_S:   w_value = XLEN'(w_imm_s);
      FMT_B:   w_value = XLEN'(w_imm_b);
      FMT_J:   w_value = XLEN'(w_imm_j);
      default: w_value = '0;
    endcase
    if (w_is_shift) w_value = w_shamt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_en) begin
      r_s1_valid <= i_in_valid;
    end
  end

  // Payload needs no reset: it is only observed when r_s1_valid is set.
  always_ff @(posedge i_clk) begin
    if (w_s1_en && i_in_valid) begin
      r_s1 <= '{inst: i_instruction, sel: i_selection};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_value     <= '0;
      r_fmt       <= FMT_NONE;
      r_illegal   <= 1'b0;
    end else if (w_s2_en) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_value   <= w_value;
        r_fmt     <= w_fmt;
        r_illegal <= w_illegal;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_value     = r_value;
  assign o_fmt       = r_fmt;
  assign o_illegal   = r_illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three configurations run in lockstep on shared stimulus,
// checked by directed vectors and by a queue-based reference model on random traffic.
module tb_imm_gen_pipe;

  typedef struct {
    logic [63:0] value;
    logic [2:0]  fmt;
    logic        ill;
  } res_t;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  sel;
    int          acc_edge;
  } txn_t;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  sel;
    int          cfg;
    logic [63:0] value;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic [2:0]  sel;

  logic        rdy64, ov64, ill64;
  logic [63:0] val64;
  logic [2:0]  fmt64;
  logic        rdy32, ov32, ill32;
  logic [31:0] val32;
  logic [2:0]  fmt32;
  logic        rdys, ovs, ills;
  logic [63:0] vals;
  logic [2:0]  fmts;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_cnt = 0;
  txn_t exp_q[$];
  bit   rst_pending = 1'b0;
  bit   armed = 1'b0;

  imm_gen_pipe #(.XLEN(64), .AUTO_FMT(1'b1)) u_dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready_c(rdy64),
    .i_instruction(inst), .i_selection(sel), .o_out_valid(ov64), .i_out_ready(out_ready),
    .o_value(val64), .o_fmt(fmt64), .o_illegal(ill64));

  imm_gen_pipe #(.XLEN(32), .AUTO_FMT(1'b1)) u_dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready_c(rdy32),
    .i_instruction(inst), .i_selection(sel), .o_out_valid(ov32), .i_out_ready(out_ready),
    .o_value(val32), .o_fmt(fmt32), .o_illegal(ill32));

  imm_gen_pipe #(.XLEN(64), .AUTO_FMT(1'b0)) u_dutsel (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready_c(rdys),
    .i_instruction(inst), .i_selection(sel), .o_out_valid(ovs), .i_out_ready(out_ready),
    .o_value(vals), .o_fmt(fmts), .o_illegal(ills));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int cfg_xlen(input int c);
    return (c == 1) ? 32 : 64;
  endfunction

  function automatic bit cfg_auto(input int c);
    return (c != 2);
  endfunction

  function automatic res_t get_out(input int c);
    res_t r;
    case (c)
      0:       r = '{val64, fmt64, ill64};
      1:       r = '{{32'h0, val32}, fmt32, ill32};
      default: r = '{vals, fmts, ills};
    endcase
    return r;
  endfunction

  function automatic logic get_ov(input int c);
    return (c == 0) ? ov64 : (c == 1) ? ov32 : ovs;
  endfunction

  function automatic logic get_rdy(input int c);
    return (c == 0) ? rdy64 : (c == 1) ? rdy32 : rdys;
  endfunction

  // Two's-complement interpretation of the low w bits of x.
  function automatic longint sext(input longint unsigned x, input int w);
    longint unsigned m;
    longint unsigned y;
    m = 64'd1 << w;
    y = x & (m - 64'd1);
    if (y >= (m >> 1)) return longint'(y - m);
    return longint'(y);
  endfunction

  // Reference model: immediate rules written as field arithmetic on the instruction word.
  function automatic res_t model(input logic [31:0] ins, input logic [2:0] s,
                                 input int xlen, input bit af);
    res_t r;
    longint unsigned w;
    int op;
    int f3;
    int f;
    longint v;
    w  = 64'(ins);
    op = int'(w % 128);
    f3 = int'((w >> 12) % 8);
    f  = 0;
    v  = 0;
    r.ill = 1'b0;
    if (!af) begin
      f = (s >= 3'd1 && s <= 3'd5) ? int'(s) : 0;
    end else begin
      case (op)
        'h03, 'h0F, 'h13, 'h67, 'h73: f = 1;
        'h1B: if (xlen == 64) f = 1; else r.ill = 1'b1;
        'h37, 'h17: f = 2;
        'h23: f = 3;
        'h63: f = 4;
        'h6F: f = 5;
        'h33: f = 0;
        'h3B: if (xlen != 64) r.ill = 1'b1;
        default: r.ill = 1'b1;
      endcase
    end
    case (f)
      1: v = sext(w >> 20, 12);
      2: v = sext(((w >> 12) % (64'd1 << 20)) * 4096, 32);
      3: v = sext(((w >> 25) % 128) * 32 + ((w >> 7) % 32), 12);
      4: v = sext(((w >> 31) % 2) * 4096 + ((w >> 7) % 2) * 2048 +
                  ((w >> 25) % 64) * 32 + ((w >> 8) % 16) * 2, 13);
      5: v = sext(((w >> 31) % 2) * (64'd1 << 20) + ((w >> 12) % 256) * 4096 +
                  ((w >> 20) % 2) * 2048 + ((w >> 21) % 1024) * 2, 21);
      default: v = 0;
    endcase
    if (af && (f3 == 1 || f3 == 5)) begin
      if (op == 'h13) v = longint'((w >> 20) % ((xlen == 64) ? 64 : 32));
      else if (op == 'h1B && xlen == 64) v = longint'((w >> 20) % 32);
    end
    r.fmt   = 3'(f);
    r.value = 64'(v);
    if (xlen == 32) r.value = r.value & 64'h0000_0000_FFFF_FFFF;
    return r;
  endfunction

  // Scoreboard: tracks accepted instructions and predicts handshake and payload every cycle.
  always @(negedge clk) begin
    bit   exp_ov;
    bit   exp_ir;
    txn_t f;
    res_t a;
    res_t e;
    if (!rst_n) begin
      exp_q.delete();
      rst_pending = 1'b1;
    end else begin
      if (rst_pending) begin
        for (int c = 0; c < 3; c++) begin
          a = get_out(c);
          chk($sformatf("rst_value_c%0d", c), a.value, 64'd0);
          chk($sformatf("rst_fmt_c%0d", c), 64'(a.fmt), 64'd0);
          chk($sformatf("rst_ill_c%0d", c), 64'(a.ill), 64'd0);
          chk($sformatf("rst_out_valid_c%0d", c), 64'(get_ov(c)), 64'd0);
          chk($sformatf("rst_in_ready_c%0d", c), 64'(get_rdy(c)), 64'd1);
        end
        rst_pending = 1'b0;
        armed = 1'b1;
      end
      if (armed) begin
        exp_ir = (exp_q.size() < 2) || out_ready;
        exp_ov = (exp_q.size() > 0) && (edge_cnt > exp_q[0].acc_edge);
        for (int c = 0; c < 3; c++) begin
          chk($sformatf("sb_in_ready_c%0d", c), 64'(get_rdy(c)), 64'(exp_ir));
          chk($sformatf("sb_out_valid_c%0d", c), 64'(get_ov(c)), 64'(exp_ov));
        end
        if (exp_ov) begin
          f = exp_q[0];
          for (int c = 0; c < 3; c++) begin
            a = get_out(c);
            e = model(f.inst, f.sel, cfg_xlen(c), cfg_auto(c));
            chk($sformatf("sb_value_c%0d_inst%h", c, f.inst), a.value, e.value);
            chk($sformatf("sb_fmt_c%0d_inst%h", c, f.inst), 64'(a.fmt), 64'(e.fmt));
            chk($sformatf("sb_ill_c%0d_inst%h", c, f.inst), 64'(a.ill), 64'(e.ill));
          end
          if (out_ready) void'(exp_q.pop_front());
        end
        if (in_valid && exp_ir) exp_q.push_back('{inst, sel, edge_cnt + 1});
      end
    end
  end

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [16] = '{7'h03, 7'h0F, 7'h13, 7'h67, 7'h73, 7'h1B, 7'h37, 7'h17,
                              7'h23, 7'h63, 7'h6F, 7'h33, 7'h3B, 7'h00, 7'h12, 7'h7F};
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(7) != 0) r[6:0] = ops[$urandom_range(15)];
    return r;
  endfunction

  task automatic check_vec(input int idx, input vec_t v);
    res_t a;
    a = get_out(v.cfg);
    chk($sformatf("vec%0d_out_valid", idx), 64'(get_ov(v.cfg)), 64'd1);
    chk($sformatf("vec%0d_value", idx), a.value, v.value);
    chk($sformatf("vec%0d_fmt", idx), 64'(a.fmt), 64'(v.fmt));
    chk($sformatf("vec%0d_ill", idx), 64'(a.ill), 64'(v.ill));
  endtask

  initial begin
    vec_t vecs[$];
    int   acc;
    int   idx;
    bit   took;
    logic [63:0] snap_val;
    logic [2:0]  snap_fmt;

    // cfg 0: XLEN=64 auto, 1: XLEN=32 auto, 2: XLEN=64 SELECTION-driven
    vecs.push_back('{32'hFFF00093, 3'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0});
    vecs.push_back('{32'h800000B7, 3'd0, 0, 64'hFFFF_FFFF_8000_0000, 3'd2, 1'b0});
    vecs.push_back('{32'hFE20AC23, 3'd0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 1'b0});
    vecs.push_back('{32'hFE000EE3, 3'd0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 3'd4, 1'b0});
    vecs.push_back('{32'hFFDFF06F, 3'd0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 1'b0});
    vecs.push_back('{32'h4030D093, 3'd0, 0, 64'd3,  3'd1, 1'b0});
    vecs.push_back('{32'h4230D093, 3'd0, 0, 64'd35, 3'd1, 1'b0});
    vecs.push_back('{32'h4230D093, 3'd0, 1, 64'd3,  3'd1, 1'b0});
    vecs.push_back('{32'h03F09093, 3'd0, 0, 64'd63, 3'd1, 1'b0});
    vecs.push_back('{32'h03F09093, 3'd0, 1, 64'd31, 3'd1, 1'b0});
    vecs.push_back('{32'h4230D09B, 3'd0, 0, 64'd3,  3'd1, 1'b0});
    vecs.push_back('{32'h800000B7, 3'd0, 1, 64'h0000_0000_8000_0000, 3'd2, 1'b0});
    vecs.push_back('{32'hFFF00093, 3'd0, 1, 64'h0000_0000_FFFF_FFFF, 3'd1, 1'b0});
    vecs.push_back('{32'h0000001B, 3'd0, 1, 64'd0, 3'd0, 1'b1});
    vecs.push_back('{32'h0000003B, 3'd0, 1, 64'd0, 3'd0, 1'b1});
    vecs.push_back('{32'h0000003B, 3'd0, 0, 64'd0, 3'd0, 1'b0});
    vecs.push_back('{32'h00000000, 3'd0, 0, 64'd0, 3'd0, 1'b1});
    vecs.push_back('{32'h00000092, 3'd0, 0, 64'd0, 3'd0, 1'b1});
    vecs.push_back('{32'h002081B3, 3'd0, 0, 64'd0, 3'd0, 1'b0});
    // SELECTION sweep on addi x1,x0,-1: S and B pick up rd=1 in inst[11:7]
    vecs.push_back('{32'hFFF00093, 3'd1, 2, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0});
    vecs.push_back('{32'hFFF00093, 3'd2, 2, 64'hFFFF_FFFF_FFF0_0000, 3'd2, 1'b0});
    vecs.push_back('{32'hFFF00093, 3'd3, 2, 64'hFFFF_FFFF_FFFF_FFE1, 3'd3, 1'b0});
    vecs.push_back('{32'hFFF00093, 3'd4, 2, 64'hFFFF_FFFF_FFFF_FFE0, 3'd4, 1'b0});
    vecs.push_back('{32'hFFF00093, 3'd5, 2, 64'hFFFF_FFFF_FFF0_0FFE, 3'd5, 1'b0});
    vecs.push_back('{32'hFFF00093, 3'd6, 2, 64'd0, 3'd0, 1'b0});
    vecs.push_back('{32'hFFF00093, 3'd7, 2, 64'd0, 3'd0, 1'b0});
    vecs.push_back('{32'h4030D093, 3'd1, 2, 64'h403, 3'd1, 1'b0});
    vecs.push_back('{32'h00000000, 3'd1, 2, 64'd0, 3'd1, 1'b0});

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; inst = '0; sel = '0;
    step(); step();
    rst_n = 1'b1;
    step();

    // Single-shot vectors: accepted at one edge, visible after the next.
    for (int i = 0; i < vecs.size(); i++) begin
      in_valid = 1'b1; inst = vecs[i].inst; sel = vecs[i].sel;
      step();
      in_valid = 1'b0;
      step();
      check_vec(i, vecs[i]);
      step();
    end

    // Back-to-back stream of the first five vectors.
    in_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      inst = vecs[j].inst; sel = vecs[j].sel;
      step();
      if (j > 0) check_vec(100 + j - 1, vecs[j-1]);
    end
    in_valid = 1'b0;
    step();
    check_vec(104, vecs[4]);
    step(); step();

    // Backpressure: consumer stalled, producer keeps offering distinct addi's.
    out_ready = 1'b0; in_valid = 1'b1; sel = 3'd0; acc = 0; idx = 0;
    snap_val = '0; snap_fmt = '0;
    for (int c = 0; c < 5; c++) begin
      inst = 32'h00100093 + (32'(idx) << 20);
      #1;
      took = rdy64;
      step();
      if (took) begin acc++; idx++; end
      if (c == 1) begin
        snap_val = val64; snap_fmt = fmt64;
        chk("bp_head_value", val64, 64'd1);
      end else if (c > 1) begin
        chk($sformatf("bp_stable_value_%0d", c), val64, snap_val);
        chk($sformatf("bp_stable_fmt_%0d", c), 64'(fmt64), 64'(snap_fmt));
        chk($sformatf("bp_stable_valid_%0d", c), 64'(ov64), 64'd1);
      end
    end
    chk("bp_accepted", 64'(acc), 64'd2);
    chk("bp_in_ready_low", 64'(rdy64), 64'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    step();

    // Reset with both stages full; neither instruction may emerge afterwards.
    out_ready = 1'b0; in_valid = 1'b1; inst = 32'h00500093;
    step();
    inst = 32'h00600093;
    step();
    chk("rst_mid_full", 64'(rdy64), 64'd0);
    in_valid = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    chk("rst_mid_out_valid", 64'(ov64), 64'd0);
    chk("rst_mid_value", val64, 64'd0);
    chk("rst_mid_fmt", 64'(fmt64), 64'd0);
    chk("rst_mid_ill", 64'(ill64), 64'd0);
    chk("rst_mid_in_ready", 64'(rdy64), 64'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rst_mid_no_emit_%0d", i), 64'(ov64 | ov32 | ovs), 64'd0);
    end

    // Random valid/ready traffic; a stalled offer is held until taken.
    took = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (!in_valid || took) begin
        in_valid = ($urandom_range(3) != 0);
        inst     = rand_inst();
        sel      = 3'($urandom_range(7));
      end
      out_ready = ($urandom_range(2) != 0);
      #1;
      took = in_valid && rdy64;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    chk("rand_drained", 64'(exp_q.size()), 64'd0);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
